branch_update_queue: RTL and testbench
======================================

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of queue entries; power of two, at least 2.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: enq_valid  input  1  execute stage presents a resolved conditional branch.
REQ-005 SHALL have port: enq_pc  input  32  PC of the resolved branch.
REQ-006 SHALL have port: enq_taken  input  1  resolved direction (1 = taken).
REQ-007 SHALL have port: enq_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port: upd_stall  input  1  predictor update port unavailable this cycle.
REQ-009 SHALL have port: write  output  1  predictor update strobe.
REQ-010 SHALL have port: write_pc  output  32  PC of the head entry.
REQ-011 SHALL have port: write_value  output  1  direction of the head entry.
REQ-012 SHALL have port: is_correct  input  1  predictor's correctness verdict for the presented update.
REQ-013 SHALL have port: branch_count  output  32  number of updates retired to the predictor.
REQ-014 SHALL have port: mispredict_count  output  32  number of retired updates with is_correct = 0.
REQ-015 SHALL have port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 SHALL implement a FIFO of DEPTH entries {pc, taken}, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 SHALL drive enq_ready = (count != DEPTH), combinationally from registered state only.
REQ-018 SHALL enqueue on a rising edge when enq_valid && enq_ready; an entry enqueued at edge N is at the head, visible on write_pc/write_value, from edge N onward if the queue was empty.
REQ-019 SHALL drive write = (count != 0) && !upd_stall, combinationally; write_pc and write_value always show the head entry, and SHALL be 0 when the queue is empty.
REQ-020 SHALL dequeue the head on a rising edge when write = 1.
REQ-021 SHALL, on a dequeue edge, increment branch_count by 1, and increment mispredict_count by 1 if is_correct = 0; both counters wrap modulo 2^32.
REQ-022 SHALL sample is_correct only in cycles where write = 1 and ignore it otherwise.
REQ-023 SHALL, on a simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-024 SHALL not enqueue when full, even if a dequeue occurs in the same cycle; enq_valid is ignored while enq_ready = 0.
REQ-025 SHALL, on a dequeue from count = 1 with no enqueue, reach count = 0 and deassert write in the following cycle.
REQ-026 SHALL keep count and the pointers unchanged while upd_stall = 1 and enq_valid = 0.

Reset
REQ-027 SHALL, while rst = 1, asynchronously clear the pointers, count, branch_count and mispredict_count to 0, giving write = 0, enq_ready = 1, write_pc = 0 and write_value = 0.
REQ-028 SHALL discard all queued entries on reset mid-operation; entry storage need not be cleared.
REQ-029 SHALL perform no enqueue, dequeue or counter update on a rising edge where rst = 1.

Structure
REQ-030 SHALL take the packed struct branch_update_t {logic [31:0] pc; logic taken;} from shared package branch_pkg, which also holds the default BUQ_DEPTH = 4.
REQ-031 SHALL place the two statistics counters in sub-module branch_stat_counters, with inputs retire and mispredict and the two 32-bit count outputs.

Verification
REQ-032 SHALL cover single entry: enqueue pc=0x100, taken=1 with upd_stall=0, is_correct=1 -> write=1 with write_pc=0x100 and write_value=1 in the next cycle, then branch_count=1, mispredict_count=0.
REQ-033 SHALL cover fill with stall: upd_stall=1, enqueue pc 0x10, 0x14, 0x18, 0x1C -> count=4 and enq_ready=0; a fifth enq_valid is dropped; release the stall -> four updates in order 0x10 to 0x1C on consecutive cycles.
REQ-034 SHALL cover simultaneous enqueue/dequeue: at count=2, enqueue and dequeue in the same cycle -> count stays 2 and FIFO order is preserved across pointer wrap after 10 such cycles.
REQ-035 SHALL cover mispredictions: 6 updates with is_correct pattern 1,0,0,1,0,1 -> branch_count=6, mispredict_count=3.
REQ-036 SHALL cover reset mid-operation: count=3, assert rst asynchronously mid-cycle -> count=0, write=0 and enq_ready=1 immediately, both counters 0, and no update after rst deasserts.
REQ-037 SHALL cover full and dequeue: count=4 with enq_valid=1 and write=1 in the same cycle -> dequeue only, count=3 next cycle.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch predictor update path.
package branch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } branch_update_t;

    localparam int BUQ_DEPTH = 4;

endpackage

// File: rtl/branch_stat_counters.sv
// Retirement statistics: total predictor updates and how many were mispredicted.
module branch_stat_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    input  logic        mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    logic [31:0] r_branch_count;
    logic [31:0] r_mispredict_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (retire) begin
            r_branch_count <= r_branch_count + 32'd1;
            if (mispredict) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

endmodule

// File: rtl/branch_update_queue.sv
// Decouples resolved branches from the predictor update port; the head entry is
// presented combinationally and retires whenever the port is not stalled.
module branch_update_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = BUQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_pc,
    input  logic                     enq_taken,
    output logic                     enq_ready,
    input  logic                     upd_stall,
    output logic                     write,
    output logic [31:0]              write_pc,
    output logic                     write_value,
    input  logic                     is_correct,
    output logic [31:0]              branch_count,
    output logic [31:0]              mispredict_count,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    branch_update_t r_mem [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;

    logic           w_empty;
    logic           w_enq;
    logic           w_deq;
    branch_update_t w_head;

    assign w_empty   = (r_count == '0);
    assign enq_ready = (r_count != CW'(DEPTH));
    assign write     = !w_empty && !upd_stall;
    assign w_enq     = enq_valid && enq_ready;
    assign w_deq     = write;
    assign w_head    = r_mem[r_rd_ptr];

    assign write_pc    = w_empty ? 32'd0 : w_head.pc;
    assign write_value = w_empty ? 1'b0  : w_head.taken;
    assign count       = r_count;

    // Storage carries no reset; stale entries are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (w_enq && !rst) begin
            r_mem[r_wr_ptr] <= '{pc: enq_pc, taken: enq_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    branch_stat_counters u_stats (
        .clk              (clk),
        .rst              (rst),
        .retire           (w_deq),
        .mispredict       (!is_correct),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_update_queue.sv
// Randomized and directed stimulus for branch_update_queue against a queue-based model.
module tb_branch_update_queue;
    import branch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    logic [31:0] enq_pc;
    logic        enq_taken;
    logic        enq_ready;
    logic        upd_stall;
    logic        write;
    logic [31:0] write_pc;
    logic        write_value;
    logic        is_correct;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
    logic [$clog2(DEPTH):0] count;

    branch_update_queue #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .enq_valid        (enq_valid),
        .enq_pc           (enq_pc),
        .enq_taken        (enq_taken),
        .enq_ready        (enq_ready),
        .upd_stall        (upd_stall),
        .write            (write),
        .write_pc         (write_pc),
        .write_value      (write_value),
        .is_correct       (is_correct),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .count            (count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of pending updates plus two plain counters.
    branch_update_t m_q[$];
    longint unsigned m_bc;
    longint unsigned m_mc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic exp_write;
        exp_write = (m_q.size() != 0) && !upd_stall;
        chk("count", 64'(count), 64'(m_q.size()));
        chk("enq_ready", 64'(enq_ready), 64'(m_q.size() != DEPTH));
        chk("write", 64'(write), 64'(exp_write));
        chk("write_pc", 64'(write_pc), (m_q.size() != 0) ? 64'(m_q[0].pc) : 64'd0);
        chk("write_value", 64'(write_value), (m_q.size() != 0) ? 64'(m_q[0].taken) : 64'd0);
        chk("branch_count", 64'(branch_count), m_bc & 64'hFFFF_FFFF);
        chk("mispredict_count", 64'(mispredict_count), m_mc & 64'hFFFF_FFFF);
    endtask

    // Called at a negedge: drive inputs, check, take the rising edge, update the model.
    task automatic cycle(input logic ev, input logic [31:0] pc, input logic tk,
                         input logic st, input logic ic);
        logic can_enq;
        logic will_deq;
        enq_valid  = ev;
        enq_pc     = pc;
        enq_taken  = tk;
        upd_stall  = st;
        is_correct = ic;
        #1;
        check_outputs();
        can_enq  = ev && (m_q.size() < DEPTH);
        will_deq = (m_q.size() > 0) && !st;
        @(posedge clk);
        if (will_deq) begin
            void'(m_q.pop_front());
            m_bc++;
            if (!ic) m_mc++;
        end
        if (can_enq) m_q.push_back('{pc: pc, taken: tk});
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        cycle(1'b0, 32'd0, 1'b0, st, 1'b1);
    endtask

    initial begin
        logic [5:0] pat;
        rst = 1'b1; enq_valid = 1'b0; enq_pc = '0; enq_taken = 1'b0;
        upd_stall = 1'b0; is_correct = 1'b1;
        m_bc = 0; m_mc = 0;

        // Reset state, with enq_valid asserted to show edges under reset do nothing.
        #1;
        check_outputs();
        enq_valid = 1'b1; enq_pc = 32'hDEAD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Single entry.
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
        chk("single_write", 64'(write), 64'd1);
        chk("single_pc", 64'(write_pc), 64'h100);
        idle(1'b0);
        idle(1'b0);
        chk("single_bc", 64'(branch_count), 64'd1);
        chk("single_mc", 64'(mispredict_count), 64'd0);

        // Fill under stall, drop a fifth, then drain in order.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10 + 32'(4 * i), i[0], 1'b1, 1'b1);
        cycle(1'b1, 32'h20, 1'b1, 1'b1, 1'b1);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(enq_ready), 64'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // Simultaneous enqueue/dequeue at count=2 across pointer wrap.
        cycle(1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h204, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h300 + 32'(4 * i), i[1], 1'b0, i[0]);
        chk("simul_count", 64'(count), 64'd2);
        chk("simul_head", 64'(write_pc), 64'h300 + 64'(4 * 8));
        idle(1'b0); idle(1'b0); idle(1'b0);

        // Mispredictions 1,0,0,1,0,1.
        pat = 6'b101001;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0, 1'b1);
            cycle(1'b0, 32'd0, 1'b0, 1'b0, pat[i]);
        end
        chk("mp_bc", 64'(branch_count), 64'd1 + 64'd4 + 64'd10 + 64'd2 + 64'd6);
        chk("mp_mc", 64'(mispredict_count), m_mc);

        // Full with enqueue and dequeue in the same cycle: dequeue only.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h5FF, 1'b1, 1'b0, 1'b1);
        chk("fulldeq_count", 64'(count), 64'd3);
        idle(1'b1);

        // Asynchronous reset mid-cycle at count=3.
        enq_valid = 1'b1; enq_pc = 32'h777; upd_stall = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_q.delete(); m_bc = 0; m_mc = 0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_ready", 64'(enq_ready), 64'd1);
        chk("rst_bc", 64'(branch_count), 64'd0);
        chk("rst_mc", 64'(mispredict_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        idle(1'b0);
        idle(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, 1'($urandom),
                  $urandom_range(0, 9) < 3, 1'($urandom));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
